// File: rtl/ahb_mem_slave.sv
// Single-port 64-bit AHB-style memory responder with configurable data-phase wait
// states, two-cycle error response for out-of-range addresses and write-to-read forwarding.
module ahb_mem_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        HSEL,
   input  logic [63:0] HADDR,
   input  logic        HTRANS,
   input  logic        HWRITE,
   input  logic [63:0] HWDATA,
   output logic [63:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) << 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t             state_q, state_d;
   logic               write_q, write_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [63:0]        hrdata_q, hrdata_d;

   logic [63:0]        offset;
   logic [IDX_W-1:0]   addr_idx;
   logic               addr_err;
   logic               accept;
   logic               mem_we;
   logic               ready;
   logic               resp;

   logic [63:0]        mem_q [DEPTH_WORDS];

   // Address decode: a plain 64-bit subtract, so addresses below the base never alias.
   always_comb begin
      offset   = HADDR - BASE_ADDR;
      addr_idx = offset[IDX_W+2:3];
      addr_err = (HADDR < BASE_ADDR) || (offset >= SPAN_BYTES);
      accept   = HSEL && HTRANS && ready;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         idx_q    <= '0;
         cnt_q    <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         hrdata_q <= hrdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DATA, S_ERR2: begin
            if (!accept)               state_d = S_IDLE;
            else if (addr_err)         state_d = S_ERR1;
            else if (WAIT_STATES > 0)  state_d = S_WAIT;
            else                       state_d = S_DATA;
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) state_d = S_DATA;
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b1;
      resp  = 1'b0;
      case (state_q)
         S_WAIT:  ready = 1'b0;
         S_ERR1: begin
            ready = 1'b0;
            resp  = 1'b1;
         end
         S_ERR2:  resp  = 1'b1;
         default: ready = 1'b1;
      endcase
      HREADY = ready;
      HRESP  = resp;
      HRDATA = hrdata_q;
   end

   // write_d/idx_d always describe the transfer entering DATA, whether it was just
   // accepted or has been waiting; a same-edge commit to that index is forwarded.
   always_comb begin
      write_d  = write_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      hrdata_d = hrdata_q;
      mem_we   = (state_q == S_DATA) && write_q;
      if (state_q == S_WAIT) cnt_d = cnt_q - 4'd1;
      if (accept && !addr_err) begin
         write_d = HWRITE;
         idx_d   = addr_idx;
         cnt_d   = 4'(WAIT_STATES);
      end
      if ((state_d == S_DATA) && !write_d) begin
         if (mem_we && (idx_q == idx_d)) hrdata_d = HWDATA;
         else                            hrdata_d = mem_q[idx_d];
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we && !RST) mem_q[idx_q] <= HWDATA;
   end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: three instances (no-wait, 3 wait states, offset base) checked
// every cycle against a transaction-level model plus directed literal expectations.
module tb_ahb_mem_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsel   [3];
   logic [63:0] haddr  [3];
   logic        htrans [3];
   logic        hwrite [3];
   logic [63:0] hwdata [3];
   logic [63:0] hrdata [3];
   logic        hready [3];
   logic        hresp  [3];

   int checks   = 0;
   int failures = 0;
   int nlow0    = 0;

   always #5 clk = ~clk;

   ahb_mem_slave #(.DEPTH_WORDS(64), .BASE_ADDR(64'h0), .WAIT_STATES(0)) u_d0 (
      .CLK(clk), .RST(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
      .HWRITE(hwrite[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]),
      .HRESP(hresp[0]));

   ahb_mem_slave #(.DEPTH_WORDS(64), .BASE_ADDR(64'h0), .WAIT_STATES(3)) u_d1 (
      .CLK(clk), .RST(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
      .HWRITE(hwrite[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]),
      .HRESP(hresp[1]));

   ahb_mem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(64'h1000), .WAIT_STATES(0)) u_d2 (
      .CLK(clk), .RST(rst), .HSEL(hsel[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]),
      .HWRITE(hwrite[2]), .HWDATA(hwdata[2]), .HRDATA(hrdata[2]), .HREADY(hready[2]),
      .HRESP(hresp[2]));

   function automatic int ws_of(input int d);
      return (d == 1) ? 3 : 0;
   endfunction

   function automatic logic [63:0] base_of(input int d);
      return (d == 2) ? 64'h1000 : 64'h0;
   endfunction

   function automatic logic [63:0] depth_of(input int d);
      return (d == 2) ? 64'd1024 : 64'd64;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Transaction model: a transfer stalls for ws_of() cycles, an error for one cycle;
   // the edge ending a ready cycle retires the current transfer and may accept the next.
   int                m_kind   [3];
   int                m_rem    [3];
   bit                m_pw     [3];
   logic [63:0]       m_pidx   [3];
   logic [63:0]       m_rdata  [3];
   bit                m_rknown [3];
   logic [63:0]       mmem [longint unsigned];

   function automatic longint unsigned key_of(input int d, input logic [63:0] idx);
      return longint'(d) * 4096 + longint'(idx);
   endfunction

   task automatic model_load(input int d);
      if (mmem.exists(key_of(d, m_pidx[d]))) begin
         m_rdata[d]  = mmem[key_of(d, m_pidx[d])];
         m_rknown[d] = 1'b1;
      end else begin
         m_rknown[d] = 1'b0;
      end
   endtask

   task automatic model_step(input int d);
      logic [63:0] a;
      if (rst) begin
         m_kind[d] = 0; m_rem[d] = 0; m_rdata[d] = '0; m_rknown[d] = 1'b1;
         return;
      end
      if (m_rem[d] == 0) begin
         if (m_kind[d] == 1 && m_pw[d]) mmem[key_of(d, m_pidx[d])] = hwdata[d];
         m_kind[d] = 0;
         if (hsel[d] && htrans[d]) begin
            a = haddr[d];
            if (a < base_of(d) || ((a - base_of(d)) >> 3) >= depth_of(d)) begin
               m_kind[d] = 2; m_rem[d] = 1;
            end else begin
               m_kind[d] = 1; m_rem[d] = ws_of(d);
               m_pw[d]   = hwrite[d];
               m_pidx[d] = (a - base_of(d)) >> 3;
               if (!m_pw[d] && m_rem[d] == 0) model_load(d);
            end
         end
      end else begin
         m_rem[d]--;
         if (m_rem[d] == 0 && m_kind[d] == 1 && !m_pw[d]) model_load(d);
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) model_step(d);
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("hready[%0d]", d), 64'(hready[d]), 64'(m_rem[d] == 0));
         chk($sformatf("hresp[%0d]", d), 64'(hresp[d]), 64'(m_kind[d] == 2));
         if (m_rknown[d]) chk($sformatf("hrdata[%0d]", d), hrdata[d], m_rdata[d]);
      end
      if (hready[0] !== 1'b1) nlow0++;
   end

   // Pipelined driver: tasks begin and end at a negedge.
   bit          pend_w  [3];
   logic [63:0] pend_wd [3];
   time         last_acc;

   task automatic wait_ready(input int d, input string what);
      bit ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         ok = (hready[d] === 1'b1);
         @(posedge clk);
         if (ok) break;
         @(negedge clk);
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL %s_timeout dut=%0d hready never 1", what, d);
      end
      last_acc = $time;
      @(negedge clk);
   endtask

   task automatic issue(input int d, input logic w, input logic [63:0] a, input logic [63:0] wd);
      hsel[d] = 1'b1; htrans[d] = 1'b1; hwrite[d] = w; haddr[d] = a;
      hwdata[d] = pend_w[d] ? pend_wd[d] : {$urandom, $urandom};
      wait_ready(d, "accept");
      pend_w[d] = w; pend_wd[d] = wd;
   endtask

   task automatic finish(input int d);
      hsel[d] = 1'b0; htrans[d] = 1'b0;
      hwdata[d] = pend_w[d] ? pend_wd[d] : {$urandom, $urandom};
      wait_ready(d, "complete");
      pend_w[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      time t_first;
      for (int d = 0; d < 3; d++) begin
         hsel[d] = 1'b0; htrans[d] = 1'b0; hwrite[d] = 1'b0;
         haddr[d] = '0; hwdata[d] = '0; pend_w[d] = 1'b0; pend_wd[d] = '0;
      end
      repeat (2) @(negedge clk);
      chk("reset_hready", 64'(hready[0]), 64'd1);
      chk("reset_hresp", 64'(hresp[1]), 64'd0);
      chk("reset_hrdata", hrdata[2], 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // No wait states: write then back-to-back read of the same word.
      issue(0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D);
      issue(0, 1'b0, 64'h40, '0);
      chk("forward_rdata", hrdata[0], 64'hDEADBEEF_CAFEF00D);
      finish(0);

      // Burst: 8 writes then 8 reads, one accept per cycle.
      for (int i = 0; i < 8; i++) begin
         issue(0, 1'b1, 64'(i * 8), 64'(i + 1));
         if (i == 0) t_first = last_acc;
      end
      for (int i = 0; i < 8; i++) begin
         issue(0, 1'b0, 64'(i * 8), '0);
         chk($sformatf("burst_rd%0d", i), hrdata[0], 64'(i + 1));
      end
      chk("burst_cycles", 64'((last_acc - t_first) / 10), 64'd15);
      finish(0);

      // Deselect with HTRANS high: nothing starts.
      hsel[0] = 1'b0; htrans[0] = 1'b1; hwrite[0] = 1'b1; haddr[0] = 64'h40;
      for (int i = 0; i < 4; i++) begin
         hwdata[0] = {$urandom, $urandom};
         @(negedge clk);
         chk("desel_hready", 64'(hready[0]), 64'd1);
      end
      htrans[0] = 1'b0;
      issue(0, 1'b0, 64'h40, '0);
      chk("desel_mem", hrdata[0], 64'hDEADBEEF_CAFEF00D);
      finish(0);

      // Three wait states; second address held during WAIT.
      issue(1, 1'b1, 64'h08, 64'h1234);
      finish(1);
      issue(1, 1'b0, 64'h08, '0);
      hwrite[1] = 1'b1; haddr[1] = 64'h10; hwdata[1] = {$urandom, $urandom};
      n = 0;
      while (hready[1] !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("ws3_low_cycles", 64'(n), 64'd3);
      chk("ws3_rdata", hrdata[1], 64'h1234);
      @(posedge clk);
      @(negedge clk);
      pend_w[1] = 1'b1; pend_wd[1] = 64'h55;
      finish(1);
      issue(1, 1'b0, 64'h10, '0);
      finish(1);
      chk("ws3_second", hrdata[1], 64'h55);

      // Reset during WAIT of a write to idx 5 drops it.
      issue(1, 1'b1, 64'h28, 64'hAAAA_0001);
      finish(1);
      issue(1, 1'b1, 64'h28, 64'hBBBB_0002);
      hsel[1] = 1'b0; htrans[1] = 1'b0; hwdata[1] = 64'hBBBB_0002;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pend_w[1] = 1'b0;
      issue(1, 1'b0, 64'h28, '0);
      finish(1);
      chk("rst_drop_write", hrdata[1], 64'hAAAA_0001);

      // Error responses with BASE_ADDR=0x1000.
      issue(2, 1'b1, 64'h1008, 64'h1111);
      issue(2, 1'b1, 64'h2FF8, 64'h2222);
      issue(2, 1'b1, 64'h1000, 64'h3333);
      issue(2, 1'b0, 64'h1008, '0);
      chk("err_pre_rdata", hrdata[2], 64'h1111);
      finish(2);
      for (int e = 0; e < 2; e++) begin
         issue(2, 1'b1, (e == 0) ? 64'h0FF8 : 64'h3000, 64'hBAD0 + 64'(e));
         chk("err1_hready", 64'(hready[2]), 64'd0);
         chk("err1_hresp", 64'(hresp[2]), 64'd1);
         hsel[2] = 1'b0; htrans[2] = 1'b0;
         @(negedge clk);
         chk("err2_hready", 64'(hready[2]), 64'd1);
         chk("err2_hresp", 64'(hresp[2]), 64'd1);
         finish(2);
         chk("err_rdata_hold", hrdata[2], 64'h1111);
      end
      issue(2, 1'b0, 64'h2FF8, '0);
      chk("err_no_alias_top", hrdata[2], 64'h2222);
      issue(2, 1'b0, 64'h1000, '0);
      chk("err_no_alias_base", hrdata[2], 64'h3333);
      finish(2);

      repeat (3) @(negedge clk);
      chk("ws0_hready_never_low", 64'(nlow0), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
